prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Host-side driver for the simulation top's instruction-programming interface.
//  - Accepts a byte stream over valid/ready.
//  - Packs bytes little-endian into 32-bit words.
//  - Writes each word to instruction memory at offsets 0,1,2,...
//  - Pulses the programming-done strobe, then watches the result signals and reports pass/fail/timeout.
// PARAMETERS
//  INST_MEM_ADDR_SIZE  10         word-address width of instruction memory; capacity = 2**INST_MEM_ADDR_SIZE words
//  TIMEOUT_CYCLES      32'd100000 cycles allowed in RUN before declaring timeout
// PORTS
//  clk                     in   1   clock
//  reset                   in   1   synchronous, active-high reset
//  in_byte                 in   8   program byte
//  in_valid                in   1   in_byte valid
//  in_last                 in   1   qualifies final byte of program (sampled with in_valid)
//  in_ready                out  1   loader accepts byte this cycle
//  inst                    out  32  word being programmed
//  inst_mem_offset         out  INST_MEM_ADDR_SIZE  word offset of inst
//  programming_data_valid  out  1   inst/inst_mem_offset valid (1-cycle pulse per word)
//  programming_done        out  1   1-cycle pulse: program complete, core may run
//  result_valid            in   1   core reported a test result this cycle
//  result_passed           in   1   result value, qualified by result_valid
//  done                    out  1   sticky: terminal state reached (pass, fail or timeout)
//  passed                  out  1   sticky: result_passed was 1 when captured
//  timed_out               out  1   sticky: TIMEOUT_CYCLES elapsed in RUN without result
//  overflow                out  1   sticky: program exceeded instruction memory capacity
//  checksum                out  32  sum of emitted words (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values:
//    - state=LOAD; in_ready=1; all other outputs 0.
//    - Byte lane = 0, word count = 0, cycle counter = 0.
//  - States: LOAD -> FLUSH -> DONE_PULSE -> RUN -> {PASS | FAIL | TIMEOUT}.
//    - Terminal states hold until reset.
//  - LOAD:
//    - in_ready=1. A byte is accepted when in_valid & in_ready.
//    - Byte k of a word goes to bits [8k+7:8k], k = 0..3.
//  - Word emit:
//    - Accepting byte lane 3 (not last) registers the word.
//    - Next cycle: programming_data_valid=1, inst=word, inst_mem_offset=word count.
//    - Word count increments; lane wraps to 0.
//    - in_ready stays 1 during the emit cycle (no bubble).
//  - Accepting a byte with in_last=1 moves to FLUSH; in_ready=0 from the next cycle.
//  - FLUSH: emit the final word, with unfilled upper lanes zero-padded.
//    - Timing: last byte accepted at T -> word valid at T+1 -> programming_done=1 at T+2 -> RUN from T+3.
//  - Overflow:
//    - Word count is INST_MEM_ADDR_SIZE+1 bits wide.
//    - Once count == 2**INST_MEM_ADDR_SIZE, further words are not emitted and overflow sets.
//    - Bytes are still accepted and drained until in_last.
//    - programming_done is still issued.
//  - RUN:
//    - The cycle counter increments every cycle.
//    - On result_valid: capture passed=result_passed, set done, go to PASS or FAIL.
//    - If the counter reaches TIMEOUT_CYCLES-1 without result_valid: timed_out=1, done=1, go to TIMEOUT.
//    - result_valid and timeout in the same cycle: result wins.
//  - result_valid outside RUN is ignored.
//  - Reset mid-operation (any state) returns to LOAD with all state cleared.
//    - The downstream memory is cleared by the same reset.
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined:
//    - checksum accumulates the 32-bit wrap-around sum of every emitted word, updated on the emit cycle.
//    - checksum clears on reset and holds after FLUSH.
//  PROG_LOADER_CHECKSUM_EN undefined:
//    - checksum is tied to 32'h0 and no adder is built.
// TESTING
//  - Bytes 13,00,50,00 | 93,00,10,00 (last) -> word 0 = 32'h00500013, word 1 = 32'h00100093; programming_done exactly 2 cycles after last accept.
//  - 6 bytes AA,BB,CC,DD,11,22 (last) -> words 32'hDDCCBBAA @0, 32'h00002211 @1 (zero-pad).
//  - Load, then result_valid=1 with result_passed=1 in RUN cycle 5 -> done=1, passed=1, timed_out=0; later result_valid ignored.
//  - TIMEOUT_CYCLES=16, no result -> timed_out=1, done=1 exactly 16 cycles after entering RUN; result_valid with timeout in cycle 16 -> PASS/FAIL instead.
//  - INST_MEM_ADDR_SIZE=2, 20 bytes -> 4 words emitted at offsets 0..3, overflow=1, in_ready stays 1 until last byte, programming_done pulses.
//  - Reset asserted during LOAD after 2 words, then 1-word program reloaded -> offset restarts at 0; with PROG_LOADER_CHECKSUM_EN, checksum == that single word.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: host-side driver for the instruction-programming interface.
// Packs a valid/ready byte stream little-endian into 32-bit words, writes them
// to instruction memory at consecutive offsets, pulses programming_done, then
// watches the core's result signals and reports pass, fail or timeout.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (running sum of emitted words).
module prog_loader #(
    parameter int          INST_MEM_ADDR_SIZE = 10,
    parameter logic [31:0] TIMEOUT_CYCLES     = 32'd100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_byte,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [31:0]                   inst,
    output logic [INST_MEM_ADDR_SIZE-1:0] inst_mem_offset,
    output logic                          programming_data_valid,
    output logic                          programming_done,
    input  logic                          result_valid,
    input  logic                          result_passed,
    output logic                          done,
    output logic                          passed,
    output logic                          timed_out,
    output logic                          overflow,
    output logic [31:0]                   checksum
);

    localparam logic [2:0] S_LOAD       = 3'd0;
    localparam logic [2:0] S_FLUSH      = 3'd1;
    localparam logic [2:0] S_DONE_PULSE = 3'd2;
    localparam logic [2:0] S_RUN        = 3'd3;
    localparam logic [2:0] S_PASS       = 3'd4;
    localparam logic [2:0] S_FAIL       = 3'd5;
    localparam logic [2:0] S_TIMEOUT    = 3'd6;

    logic [2:0]                    state_q, state_d;
    logic [1:0]                    lane_q, lane_d;
    logic [31:0]                   word_q, word_d;
    logic [INST_MEM_ADDR_SIZE:0]   count_q, count_d;
    logic [31:0]                   inst_q, inst_d;
    logic [INST_MEM_ADDR_SIZE-1:0] offset_q, offset_d;
    logic                          pdv_q, pdv_d;
    logic [31:0]                   cycle_q, cycle_d;
    logic                          done_q, done_d;
    logic                          passed_q, passed_d;
    logic                          timed_out_q, timed_out_d;
    logic                          overflow_q, overflow_d;
    logic [31:0]                   assembled;
    logic                          mem_full;

    // Count MSB set means the count has reached the memory capacity.
    assign mem_full  = count_q[INST_MEM_ADDR_SIZE];
    assign assembled = word_q | ({24'h0, in_byte} << {lane_q, 3'b000});

    // Next-state logic: byte packing, word emit, run supervision.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        word_d      = word_q;
        count_d     = count_q;
        inst_d      = inst_q;
        offset_d    = offset_q;
        pdv_d       = 1'b0;
        cycle_d     = cycle_q;
        done_d      = done_q;
        passed_d    = passed_q;
        timed_out_d = timed_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (in_last || (lane_q == 2'd3)) begin
                        word_d = 32'h0;
                        lane_d = 2'd0;
                        if (!mem_full) begin
                            pdv_d    = 1'b1;
                            inst_d   = assembled;
                            offset_d = count_q[INST_MEM_ADDR_SIZE-1:0];
                            count_d  = count_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                        if (in_last) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        word_d = assembled;
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            S_FLUSH:      state_d = S_DONE_PULSE;
            S_DONE_PULSE: state_d = S_RUN;
            S_RUN: begin
                cycle_d = cycle_q + 32'd1;
                if (result_valid) begin
                    passed_d = result_passed;
                    done_d   = 1'b1;
                    state_d  = result_passed ? S_PASS : S_FAIL;
                end else if (cycle_q == TIMEOUT_CYCLES - 32'd1) begin
                    timed_out_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_TIMEOUT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            lane_q      <= 2'd0;
            word_q      <= 32'h0;
            count_q     <= '0;
            inst_q      <= 32'h0;
            offset_q    <= '0;
            pdv_q       <= 1'b0;
            cycle_q     <= 32'h0;
            done_q      <= 1'b0;
            passed_q    <= 1'b0;
            timed_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            count_q     <= count_d;
            inst_q      <= inst_d;
            offset_q    <= offset_d;
            pdv_q       <= pdv_d;
            cycle_q     <= cycle_d;
            done_q      <= done_d;
            passed_q    <= passed_d;
            timed_out_q <= timed_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready               = (state_q == S_LOAD);
    assign programming_done       = (state_q == S_DONE_PULSE);
    assign inst                   = inst_q;
    assign inst_mem_offset        = offset_q;
    assign programming_data_valid = pdv_q;
    assign done                   = done_q;
    assign passed                 = passed_q;
    assign timed_out              = timed_out_q;
    assign overflow               = overflow_q;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Accumulate each word as it is presented to memory.
    always_comb begin
        checksum_d = checksum_q;
        if (pdv_q) begin
            checksum_d = checksum_q + inst_q;
        end
    end

    // Checksum register, cleared with the rest of the loader.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= 32'h0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader. Two instances share the stimulus: a main
// one (1024-word memory) and a small one (4-word memory) for capacity limits.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        result_valid;
    logic        result_passed;

    logic        in_ready_m, pdv_m, pd_m, done_m, passed_m, timed_out_m, overflow_m;
    logic [31:0] inst_m, checksum_m;
    logic [9:0]  off_m;

    logic        in_ready_o, pdv_o, pd_o, done_o, passed_o, timed_out_o, overflow_o;
    logic [31:0] inst_o, checksum_o;
    logic [1:0]  off_o;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int last_cyc, pd_cyc, done_cyc, ovf_pd_cyc;
    int ovf_stall;
    logic [31:0] main_words[$];
    logic [31:0] main_offs[$];
    logic [31:0] ovf_words[$];
    logic [31:0] ovf_offs[$];

    prog_loader #(.INST_MEM_ADDR_SIZE(10), .TIMEOUT_CYCLES(32'd16)) u_main (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_m), .inst(inst_m),
        .inst_mem_offset(off_m), .programming_data_valid(pdv_m),
        .programming_done(pd_m), .result_valid(result_valid),
        .result_passed(result_passed), .done(done_m), .passed(passed_m),
        .timed_out(timed_out_m), .overflow(overflow_m), .checksum(checksum_m)
    );

    prog_loader #(.INST_MEM_ADDR_SIZE(2), .TIMEOUT_CYCLES(32'd16)) u_ovf (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_o), .inst(inst_o),
        .inst_mem_offset(off_o), .programming_data_valid(pdv_o),
        .programming_done(pd_o), .result_valid(result_valid),
        .result_passed(result_passed), .done(done_o), .passed(passed_o),
        .timed_out(timed_out_o), .overflow(overflow_o), .checksum(checksum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (pdv_m) begin
            main_words.push_back(inst_m);
            main_offs.push_back(32'(off_m));
        end
        if (pd_m && pd_cyc < 0) pd_cyc = cyc;
        if (done_m && done_cyc < 0) done_cyc = cyc;
        if (in_valid && in_ready_m && in_last) last_cyc = cyc;
        if (pdv_o) begin
            ovf_words.push_back(inst_o);
            ovf_offs.push_back(32'(off_o));
        end
        if (pd_o && ovf_pd_cyc < 0) ovf_pd_cyc = cyc;
        if (in_valid && !in_ready_o) ovf_stall = 1;
        cyc++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        main_words.delete();
        main_offs.delete();
        ovf_words.delete();
        ovf_offs.delete();
        last_cyc   = -1;
        pd_cyc     = -1;
        done_cyc   = -1;
        ovf_pd_cyc = -1;
        ovf_stall  = 0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h0;
        result_valid = 1'b0; result_passed = 1'b0;
        step();
        step();
        reset = 1'b0;
        clearLog();
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic last);
        in_byte  = b;
        in_valid = 1'b1;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) step();
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxxxxxx;
    endfunction

    logic [7:0] prog_a[8]  = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] prog_b[6]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    logic [31:0] exp_cs;

    initial begin
        $display("[TB] start");
        clearLog();
        applyReset();

        // Reset values
        checkOutput("rst_in_ready", 32'(in_ready_m), 32'd1);
        checkOutput("rst_pdv", 32'(pdv_m), 32'd0);
        checkOutput("rst_pd", 32'(pd_m), 32'd0);
        checkOutput("rst_done", 32'(done_m), 32'd0);
        checkOutput("rst_passed", 32'(passed_m), 32'd0);
        checkOutput("rst_timed_out", 32'(timed_out_m), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_m), 32'd0);
        checkOutput("rst_inst", inst_m, 32'h0);
        checkOutput("rst_offset", 32'(off_m), 32'd0);
        checkOutput("rst_checksum", checksum_m, 32'h0);

        // result_valid in LOAD is ignored
        result_valid = 1'b1; result_passed = 1'b1;
        step();
        result_valid = 1'b0; result_passed = 1'b0;
        checkOutput("load_result_ignored_done", 32'(done_m), 32'd0);
        checkOutput("load_result_ignored_passed", 32'(passed_m), 32'd0);

        // Two-word program, then a pass in RUN cycle 5
        for (int i = 0; i < 8; i++) applyStimulus(prog_a[i], i == 7);
        checkOutput("a_in_ready_low", 32'(in_ready_m), 32'd0);
        step();
        step();
        checkOutput("a_nwords", 32'(main_words.size()), 32'd2);
        checkOutput("a_word0", qget(main_words, 0), 32'h00500013);
        checkOutput("a_off0", qget(main_offs, 0), 32'd0);
        checkOutput("a_word1", qget(main_words, 1), 32'h00100093);
        checkOutput("a_off1", qget(main_offs, 1), 32'd1);
        checkOutput("a_pd_latency", 32'(pd_cyc - last_cyc), 32'd2);
`ifdef PROG_LOADER_CHECKSUM_EN
        exp_cs = 32'h006000A6;
`else
        exp_cs = 32'h0;
`endif
        checkOutput("a_checksum", checksum_m, exp_cs);
        waitUntil(pd_cyc + 5);
        result_valid = 1'b1; result_passed = 1'b1;
        step();
        result_valid = 1'b0; result_passed = 1'b0;
        step();
        step();
        checkOutput("a_done_cycle", 32'(done_cyc - pd_cyc), 32'd6);
        checkOutput("a_done", 32'(done_m), 32'd1);
        checkOutput("a_passed", 32'(passed_m), 32'd1);
        checkOutput("a_timed_out", 32'(timed_out_m), 32'd0);
        result_valid = 1'b1; result_passed = 1'b0;
        step();
        result_valid = 1'b0;
        repeat (25) step();
        checkOutput("a_late_result_passed", 32'(passed_m), 32'd1);
        checkOutput("a_late_timed_out", 32'(timed_out_m), 32'd0);

        // Six bytes, zero-padded final word, then timeout
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(prog_b[i], i == 5);
        step();
        step();
        checkOutput("b_nwords", 32'(main_words.size()), 32'd2);
        checkOutput("b_word0", qget(main_words, 0), 32'hDDCCBBAA);
        checkOutput("b_off0", qget(main_offs, 0), 32'd0);
        checkOutput("b_word1", qget(main_words, 1), 32'h00002211);
        checkOutput("b_off1", qget(main_offs, 1), 32'd1);
        repeat (25) step();
        checkOutput("b_timeout_cycle", 32'(done_cyc - pd_cyc), 32'd17);
        checkOutput("b_timed_out", 32'(timed_out_m), 32'd1);
        checkOutput("b_done", 32'(done_m), 32'd1);
        checkOutput("b_passed", 32'(passed_m), 32'd0);

        // Result in the final RUN cycle beats the timeout
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(prog_a[i], i == 7);
        step();
        step();
        waitUntil(pd_cyc + 16);
        result_valid = 1'b1; result_passed = 1'b0;
        step();
        result_valid = 1'b0;
        repeat (5) step();
        checkOutput("c_done_cycle", 32'(done_cyc - pd_cyc), 32'd17);
        checkOutput("c_done", 32'(done_m), 32'd1);
        checkOutput("c_timed_out", 32'(timed_out_m), 32'd0);
        checkOutput("c_passed", 32'(passed_m), 32'd0);

        // Twenty bytes into a four-word memory
        applyReset();
        for (int i = 0; i < 20; i++) applyStimulus(8'(i + 1), i == 19);
        step();
        step();
        step();
        checkOutput("d_ovf_nwords", 32'(ovf_words.size()), 32'd4);
        checkOutput("d_ovf_word0", qget(ovf_words, 0), 32'h04030201);
        checkOutput("d_ovf_off1", qget(ovf_offs, 1), 32'd1);
        checkOutput("d_ovf_off2", qget(ovf_offs, 2), 32'd2);
        checkOutput("d_ovf_word3", qget(ovf_words, 3), 32'h100F0E0D);
        checkOutput("d_ovf_off3", qget(ovf_offs, 3), 32'd3);
        checkOutput("d_ovf_overflow", 32'(overflow_o), 32'd1);
        checkOutput("d_ovf_no_stall", 32'(ovf_stall), 32'd0);
        checkOutput("d_ovf_pd_latency", 32'(ovf_pd_cyc - last_cyc), 32'd2);
        checkOutput("d_main_nwords", 32'(main_words.size()), 32'd5);
        checkOutput("d_main_word4", qget(main_words, 4), 32'h14131211);
        checkOutput("d_main_off4", qget(main_offs, 4), 32'd4);
        checkOutput("d_main_overflow", 32'(overflow_m), 32'd0);

        // Reset mid-load, then reload a one-word program
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(8'(i + 1), 1'b0);
        step();
        step();
        checkOutput("e_pre_nwords", 32'(main_words.size()), 32'd2);
        applyReset();
        applyStimulus(8'h78, 1'b0);
        applyStimulus(8'h56, 1'b0);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h12, 1'b1);
        step();
        step();
        step();
        checkOutput("e_nwords", 32'(main_words.size()), 32'd1);
        checkOutput("e_word0", qget(main_words, 0), 32'h12345678);
        checkOutput("e_off0", qget(main_offs, 0), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        exp_cs = 32'h12345678;
`else
        exp_cs = 32'h0;
`endif
        checkOutput("e_checksum", checksum_m, exp_cs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
